// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver sharing the transmitter's bd_tick.
// Defining UART_RX_FRAME_ERR_EN adds a sampled stop bit and the frame_err output.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bd_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] S_LAST = 8'(STOP_TICKS - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);
  state_t state, state_d;
  logic rx_m, rx_s;
  logic [7:0] s, s_d;
  logic [2:0] n, n_d;
  logic [DATA_BITS-1:0] b, b_d;
  logic done_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      rx_done <= 1'b0;
      dout    <= '0;
    end else begin
      state   <= state_d;
      s       <= s_d;
      n       <= n_d;
      b       <= b_d;
      rx_done <= done_d;
      if (done_d) dout <= 8'(b);
    end
  // IDLE watches the line every clk; all other states move only on bd_tick.
  always_comb begin
    state_d = state;
    s_d     = s;
    n_d     = n;
    b_d     = b;
    done_d  = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      START:
        if (bd_tick) begin
          if (s == 8'd7) begin
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else s_d = s + 8'd1;
        end
      DATA:
        if (bd_tick) begin
          if (s == 8'd15) begin
            s_d = '0;
            b_d = {rx_s, b[DATA_BITS-1:1]};
            if (n == N_LAST) state_d = STOP;
            else n_d = n + 3'd1;
          end else s_d = s + 8'd1;
        end
      STOP:
        if (bd_tick) begin
          if (s == S_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else s_d = s + 8'd1;
        end
      default: state_d = IDLE;
    endcase
  end
`ifdef UART_RX_FRAME_ERR_EN
  localparam logic [7:0] S_MID = 8'(STOP_TICKS / 2 - 1);
  logic flag, flag_d;
  always_comb flag_d = (state == STOP && bd_tick && s == S_MID) ? rx_s : flag;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flag      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      flag <= flag_d;
      if (done_d) frame_err <= ~flag_d;
    end
`endif
endmodule
